golomb_bit_packer: RTL and testbench

- Stage 5 of the LOCO-I encoder pipeline. Sits directly downstream of the error-mapping / context-update stage.
- Consumes the mapped error MErrval and the Golomb parameter k, one symbol per cycle.
- Produces the JPEG-LS limited-length Golomb-Rice codeword and packs it MSB-first into a byte stream, with 0xFF bit-stuffing.
- Provides end-of-scan flush and padding.

---
 rtl/golomb_bit_packer.sv | 142 ++++++++++++++
 tb/tb_golomb_bit_packer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/golomb_bit_packer.sv
// golomb_bit_packer
//   Final stage of the LOCO-I encoder. Each accepted symbol (MErrval, k) is
//   turned into a limited-length Golomb-Rice codeword and appended MSB-first
//   to a bit accumulator. The accumulator is drained one byte per cycle into
//   a valid/ready byte stream. After an 0xFF byte, only 7 payload bits go
//   into the next byte, whose top bit is forced to 0 (bit stuffing).
//   A flush pulse pads the tail out to a whole byte and closes the scan.
//   If the last byte sent was 0xFF, one 0x00 byte is added. done then
//   pulses for one cycle.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   en, MErrval, k, in_ready symbol input (accepted on en && in_ready)
//   flush                    end-of-scan pulse
//   out_byte, out_valid,
//   out_ready                byte stream output handshake
//   done                     one-cycle pulse when flush processing completes
//   byte_count               bytes handed off since reset
module golomb_bit_packer #(
    parameter int LIMIT = 32,
    parameter int QBPP  = 8,
    parameter int BUF_W = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [8:0]  MErrval,
    input  logic [3:0]  k,
    output logic        in_ready,
    input  logic        flush,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done,
    output logic [23:0] byte_count
);
    localparam int         FW   = $clog2(BUF_W + 1);
    localparam logic [8:0] QMAX = 9'(LIMIT - QBPP - 1);

    typedef enum logic [1:0] {RUN, FLUSH, FIN} state_t;

    state_t           state;
    logic [BUF_W-1:0] acc;      // held bits, MSB-aligned; bits below fill are 0
    logic [FW-1:0]    fill;
    logic             stuff;    // previous byte was 0xFF

    // Codeword construction
    logic [8:0]       q, low_mask;
    logic [LIMIT-1:0] code_val, code_msb;
    logic [FW-1:0]    code_len;
    logic [BUF_W-1:0] code_top;

    always_comb begin
        q        = MErrval >> k;
        low_mask = (9'd1 << k) - 9'd1;
        if (q >= QMAX) begin
            // Escape: the leading zeros are implicit in the left alignment below
            code_val = LIMIT'({1'b1, QBPP'(MErrval - 9'd1)});
            code_len = FW'(LIMIT);
        end else begin
            code_val = (LIMIT'(1) << k) | LIMIT'(MErrval & low_mask);
            code_len = FW'(q) + FW'(k) + FW'(1);
        end
        code_msb = code_val << (FW'(LIMIT) - code_len);
        code_top = {code_msb, {(BUF_W-LIMIT){1'b0}}};
    end

    // Drain / append
    logic [FW-1:0]    need, consumed, remain, fill_next;
    logic             can_load, have_unit, load_full, load_pad, load_zero, accept;
    logic [BUF_W-1:0] acc_shift, acc_next;
    logic [7:0]       byte_new;

    always_comb begin
        in_ready  = !reset && (state == RUN) && (fill <= FW'(BUF_W - LIMIT));
        need      = stuff ? FW'(7) : FW'(8);
        can_load  = !out_valid || out_ready;
        have_unit = fill >= need;
        load_full = (state != FIN) && have_unit && can_load;
        // Tail shorter than a byte: zeros below it come for free from acc
        load_pad  = (state == FLUSH) && !have_unit && (fill != '0) && can_load;
        load_zero = (state == FIN) && stuff && can_load;
        consumed  = load_full ? need : (load_pad ? fill : '0);
        accept    = en && in_ready;
        remain    = fill - consumed;
        acc_shift = acc << consumed;
        // New code lands directly behind whatever is left after the drain
        acc_next  = accept ? (acc_shift | (code_top >> remain)) : acc_shift;
        fill_next = remain + (accept ? code_len : '0);
        if (load_zero)
            byte_new = 8'h00;
        else if (stuff)
            byte_new = {1'b0, acc[BUF_W-1 -: 7]};
        else
            byte_new = acc[BUF_W-1 -: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            acc        <= '0;
            fill       <= '0;
            stuff      <= 1'b0;
            out_byte   <= 8'h00;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            byte_count <= '0;
        end else begin
            acc  <= acc_next;
            fill <= fill_next;
            done <= 1'b0;

            if (out_valid && out_ready)
                byte_count <= byte_count + 24'd1;

            if (load_full || load_pad || load_zero) begin
                out_byte  <= byte_new;
                out_valid <= 1'b1;
                stuff     <= (byte_new == 8'hFF);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                RUN:   if (flush) state <= FLUSH;
                FLUSH: if (load_pad || fill == '0) state <= FIN;
                FIN: begin
                    // Wait until the final byte (including any 0x00) is taken
                    if (!stuff && can_load) begin
                        done  <= 1'b1;
                        stuff <= 1'b0;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // A symbol offered while not ready is dropped
    a_no_drop: assert property (@(posedge clk) disable iff (reset) !(en && !in_ready));

endmodule

// File: tb/tb_golomb_bit_packer.sv
// Directed bench for golomb_bit_packer: hand-computed byte streams for
// ordinary, escape, stuffed and trailing-0xFF codes, backpressure and
// mid-stream reset.
module tb_golomb_bit_packer;
    logic        clk = 1'b0;
    logic        reset, en, flush, out_ready;
    logic [8:0]  MErrval;
    logic [3:0]  k;
    logic        in_ready, out_valid, done;
    logic [7:0]  out_byte;
    logic [23:0] byte_count;

    golomb_bit_packer dut (
        .clk(clk), .reset(reset), .en(en), .MErrval(MErrval), .k(k),
        .in_ready(in_ready), .flush(flush), .out_byte(out_byte),
        .out_valid(out_valid), .out_ready(out_ready), .done(done),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int cyc = 0, done_cnt = 0, hs_cyc = -1, done_cyc = -1;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got.push_back(out_byte);
            hs_cyc = cyc;
        end
        if (!reset && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [8:0] m, input logic [3:0] kk);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(in_ready), 1);
        MErrval = m;
        k       = kk;
        en      = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic do_flush();
        int n  = 0;
        int d0 = done_cnt;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done_cnt - d0), 1);
    endtask

    task automatic check_bytes(input string tag);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hxx, 32'(exp_q[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, n;
        reset = 1'b1; en = 1'b0; flush = 1'b0; out_ready = 1'b1;
        MErrval = '0; k = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_byte", 32'(out_byte), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(byte_count), 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: two 0011 codes -> 0x33
        got.delete();
        send(9'd5, 4'd1);
        send(9'd5, 4'd1);
        do_flush();
        exp_q = '{8'h33};
        check_bytes("t1");
        chk("t1_count", 32'(byte_count), 1);

        // 2: escape, 23 zeros + 1 + 0x2B
        got.delete();
        send(9'd300, 4'd0);
        do_flush();
        exp_q = '{8'h00, 8'h00, 8'h01, 8'h2B};
        check_bytes("t2");
        chk("t2_count", 32'(byte_count), 5);

        // 3: nine 1s -> FF then stuffed pad 0x40
        got.delete();
        send(9'd255, 4'd8);
        do_flush();
        exp_q = '{8'hFF, 8'h40};
        check_bytes("t3");
        chk("t3_count", 32'(byte_count), 7);
        chk("t3_done_lat", 32'(done_cyc - hs_cyc), 1);

        // 3b: nine 1s + 0011 -> FF, then {0,1001100} = 0x4C
        got.delete();
        send(9'd255, 4'd8);
        send(9'd5, 4'd1);
        do_flush();
        exp_q = '{8'hFF, 8'h4C};
        check_bytes("t3b");
        chk("t3b_count", 32'(byte_count), 9);

        // 4: eight 1s -> FF then trailing 0x00
        got.delete();
        send(9'd127, 4'd7);
        do_flush();
        exp_q = '{8'hFF, 8'h00};
        check_bytes("t4");
        chk("t4_count", 32'(byte_count), 11);
        chk("t4_done_lat", 32'(done_cyc - hs_cyc), 1);

        // 5: escapes every cycle under 10 cycles of backpressure
        got.delete();
        out_ready = 1'b0;
        MErrval = 9'd300; k = 4'd0;
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk("t5_in_ready_low", 32'(in_ready), 0);
                chk("t5_hold_valid", 32'(out_valid), 1);
                chk("t5_hold_byte", 32'(out_byte), 0);
            end
            en = in_ready && (sent < 4);
            if (en) sent++;
        end
        chk("t5_sent_stall", 32'(sent), 2);
        out_ready = 1'b1;
        n = 0;
        while (sent < 4 && n < 100) begin
            @(negedge clk);
            en = in_ready;
            if (in_ready) sent++;
            n++;
        end
        @(negedge clk);
        en = 1'b0;
        chk("t5_sent", 32'(sent), 4);
        do_flush();
        exp_q = '{8'h00, 8'h00, 8'h01, 8'h2B, 8'h00, 8'h00, 8'h01, 8'h2B,
                  8'h00, 8'h00, 8'h01, 8'h2B, 8'h00, 8'h00, 8'h01, 8'h2B};
        check_bytes("t5");
        chk("t5_count", 32'(byte_count), 27);

        // 6: reset with 20 bits held and a byte pending
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(9'd5, 4'd1);
        @(negedge clk);
        chk("t6_pre_valid", 32'(out_valid), 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        chk("t6_count_clr", 32'(byte_count), 0);
        chk("t6_valid_clr", 32'(out_valid), 0);
        got.delete();
        send(9'd5, 4'd1);
        do_flush();
        exp_q = '{8'h30};
        check_bytes("t6");
        chk("t6_count", 32'(byte_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
